// File: rtl/dm_access_master.sv
// Data-memory access initiator: one CPU load/store becomes one word-aligned bus
// transaction with byte enables, lane-replicated store data and extended load data.
module dm_access_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_type,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [2:0]     type_reg, type_next;
  logic [1:0]     lane_reg, lane_next;
  logic           done_reg, done_next;
  logic           mis_reg, mis_next;
  logic           to_reg, to_next;
  logic [31:0]    rdata_reg, rdata_next;
  logic           req_reg, req_next;
  logic           we_reg, we_next;
  logic [31:0]    addr_reg, addr_next;
  logic [3:0]     be_reg, be_next;
  logic [31:0]    wdata_reg, wdata_next;

  logic           access_ok;
  logic [3:0]     be_calc;
  logic [31:0]    wdata_calc;
  logic [7:0]     rbyte [4];
  logic [7:0]     sel_byte;
  logic [15:0]    sel_half;
  logic [31:0]    load_val;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
      assign rbyte[gi] = bus_rdata[8*gi +: 8];
    end
  endgenerate

  // Alignment, byte enables and replicated store data for the incoming request
  always_comb begin
    access_ok  = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = {4{cpu_wdata[7:0]}};
    case (cpu_type)
      3'd0: begin
        access_ok  = (cpu_addr[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = cpu_wdata;
      end
      3'd1, 3'd2: begin
        access_ok  = ~cpu_addr[0];
        be_calc    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{cpu_wdata[15:0]}};
      end
      3'd3, 3'd4: begin
        access_ok  = 1'b1;
        be_calc    = 4'b0001 << cpu_addr[1:0];
      end
      default: access_ok = 1'b0;
    endcase
  end

  assign sel_byte = rbyte[lane_reg];
  assign sel_half = lane_reg[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};

  always_comb begin
    load_val = 32'h0;
    case (type_reg)
      3'd0:    load_val = bus_rdata;
      3'd1:    load_val = {{16{sel_half[15]}}, sel_half};
      3'd2:    load_val = {16'h0, sel_half};
      3'd3:    load_val = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    load_val = {24'h0, sel_byte};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    type_next  = type_reg;
    lane_next  = lane_reg;
    done_next  = 1'b0;
    mis_next   = 1'b0;
    to_next    = 1'b0;
    rdata_next = rdata_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    be_next    = be_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          if (!access_ok) begin
            // Rejected without touching the bus; reported next cycle
            done_next  = 1'b1;
            mis_next   = 1'b1;
            rdata_next = 32'h0;
          end else begin
            state_next = WAIT;
            cnt_next   = '0;
            type_next  = cpu_type;
            lane_next  = cpu_addr[1:0];
            req_next   = 1'b1;
            we_next    = cpu_we;
            addr_next  = {cpu_addr[31:2], 2'b00};
            be_next    = be_calc;
            wdata_next = wdata_calc;
          end
        end
      end
      WAIT: begin
        if (bus_ack) begin
          state_next = RESP;
          req_next   = 1'b0;
          done_next  = 1'b1;
          rdata_next = we_reg ? 32'h0 : load_val;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next = RESP;
          req_next   = 1'b0;
          done_next  = 1'b1;
          to_next    = 1'b1;
          rdata_next = 32'h0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      type_reg  <= 3'd0;
      lane_reg  <= 2'd0;
      done_reg  <= 1'b0;
      mis_reg   <= 1'b0;
      to_reg    <= 1'b0;
      rdata_reg <= 32'h0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'h0;
      be_reg    <= 4'h0;
      wdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      type_reg  <= type_next;
      lane_reg  <= lane_next;
      done_reg  <= done_next;
      mis_reg   <= mis_next;
      to_reg    <= to_next;
      rdata_reg <= rdata_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      be_reg    <= be_next;
      wdata_reg <= wdata_next;
    end
  end

  assign cpu_busy     = (state_reg != IDLE);
  assign cpu_done     = done_reg;
  assign cpu_rdata    = rdata_reg;
  assign err_misalign = mis_reg;
  assign err_timeout  = to_reg;
  assign bus_req      = req_reg;
  assign bus_we       = we_reg;
  assign bus_addr     = addr_reg;
  assign bus_be       = be_reg;
  assign bus_wdata    = wdata_reg;

endmodule

// File: tb/tb_dm_access_master.sv
// Randomised scoreboard bench for dm_access_master: expected completions and bus
// transactions are queued by the driver and consumed by independent monitors.
module tb_dm_access_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_type = 3'd0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_busy, cpu_done, err_misalign, err_timeout;
  logic [31:0] cpu_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  dm_access_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .err_misalign(err_misalign), .err_timeout(err_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
    int          done_cyc;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;

  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: access size in bytes, 0 for an illegal type
  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [31:0] a);
    int s   = size_of(t);
    int off = int'(a[1:0]);
    int m   = ((1 << s) - 1) << off;
    return 4'(m & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] t, input logic [31:0] w);
    int s = size_of(t);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(w >> (8 * (i % s)));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint s = longint'(size_of(t));
    longint v = ({32'h0, rd} >> (8 * int'(a[1:0]))) & ((longint'(1) << (8 * s)) - 1);
    if ((t == 3'd1 || t == 3'd3) && v >= (longint'(1) << (8 * s - 1)))
      v = v - (longint'(1) << (8 * s));
    return 32'(v);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (cpu_busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      $display("FAIL idle_wait: cpu_busy still 1 after 20 cycles, required 0");
    end
  endtask

  // One CPU access; d = WAIT cycles before the responder raises bus_ack
  task automatic do_access(input logic we, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int d, input bit spurious);
    int s;
    bit mis;
    int c0;
    done_exp_t de;
    bus_exp_t be;
    s   = size_of(t);
    mis = (s == 0) || ((int'(a[1:0]) % s) != 0);
    wait_idle();
    cpu_req = 1'b1; cpu_we = we; cpu_type = t; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    c0 = cyc;
    cpu_req = 1'b0;
    cpu_we = 1'($urandom); cpu_type = 3'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    if (mis) begin
      de = '{rdata: 32'h0, mis: 1'b1, to: 1'b0, done_cyc: c0};
      done_q.push_back(de);
    end else begin
      be = '{addr: {a[31:2], 2'b00}, be: ref_be(t, a), we: we,
             wdata: ref_wdata(t, wd), len: (d < TO) ? d + 1 : TO};
      bus_q.push_back(be);
      de.mis = 1'b0;
      de.to = (d >= TO);
      de.rdata = (we || d >= TO) ? 32'h0 : ref_load(t, a, rd);
      de.done_cyc = c0 + ((d < TO) ? d + 1 : TO);
      done_q.push_back(de);
    end
    for (int i = 0; i < d; i++) begin
      // Requests while the master is busy must be ignored
      if (spurious && !mis && i < TO) begin
        cpu_req = 1'b1; cpu_type = 3'd0; cpu_addr = $urandom & 32'hFFFF_FFFC;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
    end
    bus_ack = 1'b1; bus_rdata = rd;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = $urandom;
  endtask

  // Completion monitor
  logic [31:0] hold_rdata = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      hold_rdata = 32'h0;
    end else if (cpu_done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got cpu_done=1 required no completion (t=%0t)", $time);
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        check("cpu_rdata", cpu_rdata, e.rdata);
        check("err_misalign", 32'(err_misalign), 32'(e.mis));
        check("err_timeout", 32'(err_timeout), 32'(e.to));
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        hold_rdata = e.rdata;
      end
    end else begin
      check("err_idle", {30'h0, err_misalign, err_timeout}, 32'h0);
      check("rdata_hold", cpu_rdata, hold_rdata);
    end
  end

  // Bus monitor
  logic     prev_req = 1'b0;
  bus_exp_t cur;
  int       cur_len = 0;
  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_bus_req: got bus_req=1 addr=0x%08h required 0", bus_addr);
        cur = '{addr: bus_addr, be: bus_be, we: bus_we, wdata: bus_wdata, len: 0};
      end else begin
        cur = bus_q.pop_front();
        check("bus_addr", bus_addr, cur.addr);
        check("bus_be", 32'(bus_be), 32'(cur.be));
        check("bus_we", 32'(bus_we), 32'(cur.we));
        if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
      end
      cur_len = 1;
    end else if (bus_req && prev_req) begin
      cur_len++;
      check("bus_stable", {bus_addr[31:2], bus_we, bus_be}, {cur.addr[31:2], cur.we, cur.be});
    end else if (!bus_req && prev_req) begin
      check("bus_req_len", 32'(cur_len), 32'(cur.len));
    end
    prev_req = bus_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(cpu_busy), 32'h0);
    check("rst_done", 32'(cpu_done), 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_bus_misc", {bus_we, bus_be, 27'h0}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    @(posedge clk); #1;

    do_access(1'b1, 3'd3, 32'h1003, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 0);
    do_access(1'b0, 3'd3, 32'h1001, 32'h0, 32'h1234_80FF, 0, 0);
    do_access(1'b0, 3'd4, 32'h1001, 32'h0, 32'h1234_80FF, 0, 0);
    do_access(1'b0, 3'd1, 32'h1002, 32'h0, 32'h8001_7FFF, 0, 0);
    do_access(1'b0, 3'd2, 32'h1002, 32'h0, 32'h8001_7FFF, 0, 0);
    do_access(1'b0, 3'd0, 32'h1002, 32'h0, 32'h1111_2222, 0, 0);
    do_access(1'b0, 3'd6, 32'h1000, 32'h0, 32'h1111_2222, 0, 0);
    do_access(1'b0, 3'd0, 32'h1000, 32'h0, 32'hCAFE_F00D, TO, 0);
    do_access(1'b0, 3'd0, 32'h1000, 32'h0, 32'hCAFE_F00D, TO - 1, 0);
    do_access(1'b1, 3'd1, 32'h2002, 32'h1234_BEEF, 32'h0, TO + 1, 0);
    do_access(1'b0, 3'd0, 32'h2000, 32'h0, 32'h7654_3210, 3, 1);

    for (int n = 0; n < 300; n++) begin
      do_access(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, TO + 2)), ($urandom_range(0, 3) == 0));
    end

    // Reset while WAIT: transaction abandoned, no completion
    wait_idle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = 3'd0; cpu_addr = 32'h3000;
    bus_q.push_back('{addr: 32'h3000, be: 4'hF, we: 1'b0, wdata: 32'h0, len: 1});
    @(posedge clk); #1;
    cpu_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_bus_req", 32'(bus_req), 32'h0);
    check("rst_mid_done", 32'(cpu_done), 32'h0);
    check("rst_mid_busy", 32'(cpu_busy), 32'h0);
    @(posedge clk); #1;
    do_access(1'b0, 3'd3, 32'h4002, 32'h0, 32'h00F0_0000, 1, 0);

    repeat (10) @(posedge clk);
    #1;
    check("done_q_empty", 32'(done_q.size()), 32'h0);
    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
